// File: rtl/tt_um_jleugeri_ttt_event_router.sv
// tt_um_jleugeri_ttt_event_router: multi-cycle saturating event router over a programmable good/bad synapse table
module tt_um_jleugeri_ttt_event_router #(
   parameter int NUM_PROCESSORS = 10,
   parameter int NEW_TOKENS_BITS = 4,
   localparam int IDX_BITS = $clog2(NUM_PROCESSORS)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      go,
   input  logic [2*NUM_PROCESSORS-1:0]               tstartstop,
   input  logic                                      cfg_we,
   input  logic [IDX_BITS-1:0]                       cfg_src,
   input  logic [IDX_BITS-1:0]                       cfg_tgt,
   input  logic [1:0]                                cfg_code,
   output logic                                      busy,
   output logic                                      done,
   output logic [IDX_BITS-1:0]                       src_idx,
   output logic [NEW_TOKENS_BITS*NUM_PROCESSORS-1:0] new_good_tokens,
   output logic [NEW_TOKENS_BITS*NUM_PROCESSORS-1:0] new_bad_tokens
);
   localparam int N = NUM_PROCESSORS;
   localparam int B = NEW_TOKENS_BITS;
   localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(N - 1);
   localparam logic signed [B-1:0] MAX = {1'b0, {(B-1){1'b1}}};
   localparam logic signed [B-1:0] MIN = {1'b1, {(B-1){1'b0}}};
   localparam logic signed [B-1:0] ONE = {{(B-1){1'b0}}, 1'b1};
   typedef enum logic [1:0] {IDLE, SCAN, FANOUT, DONE} state_t;
   state_t state, state_nx;
   logic [2*N-1:0] ev;
   logic [1:0] syn [N][N];
   logic signed [B-1:0] good_acc [N];
   logic signed [B-1:0] bad_acc [N];
   logic [IDX_BITS-1:0] tgt;
   logic [1:0] pair;
   logic [1:0] code;
   logic active, last_src, last_tgt, ready;
   assign pair     = ev[2*src_idx +: 2];
   assign active   = pair[0] ^ pair[1];
   assign code     = syn[src_idx][tgt];
   assign last_src = src_idx == LAST;
   assign last_tgt = tgt == LAST;
   assign ready    = state == IDLE || state == DONE;
   function automatic logic signed [B-1:0] step(input logic signed [B-1:0] a, input logic up);
      return up ? (a == MAX ? a : a + ONE) : (a == MIN ? a : a - ONE);
   endfunction
   // next-state: scan sources, fan out active ones over every target
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = go ? SCAN : state;
         SCAN:       state_nx = active ? FANOUT : (last_src ? DONE : SCAN);
         FANOUT:     state_nx = last_tgt ? (last_src ? DONE : SCAN) : FANOUT;
         default:    state_nx = IDLE;
      endcase
   end
   // state, table, snapshot, counters and saturating accumulators
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         src_idx <= '0;
         tgt     <= '0;
         ev      <= '0;
         for (int i = 0; i < N; i++) begin
            good_acc[i] <= '0;
            bad_acc[i]  <= '0;
            for (int k = 0; k < N; k++) syn[i][k] <= 2'b00;
         end
      end else begin
         state <= state_nx;
         busy  <= state_nx == SCAN || state_nx == FANOUT;
         done  <= state_nx == DONE && state != DONE;
         if (ready && cfg_we && cfg_src <= LAST && cfg_tgt <= LAST) syn[cfg_src][cfg_tgt] <= cfg_code;
         if (ready && go) begin
            ev      <= tstartstop;
            src_idx <= '0;
            tgt     <= '0;
            for (int i = 0; i < N; i++) begin
               good_acc[i] <= '0;
               bad_acc[i]  <= '0;
            end
         end else if (state == SCAN) begin
            if (active) tgt <= '0;
            else if (!last_src) src_idx <= src_idx + 1'b1;
         end else if (state == FANOUT) begin
            if (code == 2'b01) good_acc[tgt] <= step(good_acc[tgt], pair[0]);
            if (code == 2'b10) bad_acc[tgt] <= step(bad_acc[tgt], pair[0]);
            if (!last_tgt) tgt <= tgt + 1'b1;
            else if (!last_src) src_idx <= src_idx + 1'b1;
         end
      end
   end
   for (genvar j = 0; j < N; j++) begin : g_out
      assign new_good_tokens[j*B +: B] = good_acc[j];
      assign new_bad_tokens[j*B +: B]  = bad_acc[j];
   end
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_router.sv
// tb_tt_um_jleugeri_ttt_event_router: vector table, corner sequences and random frames against a reference model
module tb_tt_um_jleugeri_ttt_event_router;
   localparam int N = 10;
   localparam int B = 4;
   localparam int IW = $clog2(N);
   logic clk = 1'b0, reset = 1'b1, go = 1'b0, cfg_we = 1'b0;
   logic [2*N-1:0] tstartstop = '0;
   logic [IW-1:0] cfg_src = '0, cfg_tgt = '0;
   logic [1:0] cfg_code = '0;
   logic busy, done;
   logic [IW-1:0] src_idx;
   logic [N*B-1:0] new_good_tokens, new_bad_tokens;
   int checks = 0, failures = 0;
   int tbl [N][N];
   int eg [N], eb [N];
   typedef struct {
      logic [2*N-1:0] ev;
      int cyc;
      int g5;
      int b7;
   } vec_t;
   vec_t vt [5];

   tt_um_jleugeri_ttt_event_router #(.NUM_PROCESSORS(N), .NEW_TOKENS_BITS(B)) dut (
      .clk(clk), .reset(reset), .go(go), .tstartstop(tstartstop),
      .cfg_we(cfg_we), .cfg_src(cfg_src), .cfg_tgt(cfg_tgt), .cfg_code(cfg_code),
      .busy(busy), .done(done), .src_idx(src_idx),
      .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return v > 7 ? 7 : (v < -8 ? -8 : v);
   endfunction

   function automatic logic [N*B-1:0] pack(input int a [N]);
      logic [N*B-1:0] v;
      for (int j = 0; j < N; j++) v[j*B +: B] = B'(a[j]);
      return v;
   endfunction

   task automatic model(input logic [2*N-1:0] ev, output int cyc);
      cyc = 1 + N;
      for (int j = 0; j < N; j++) begin
         eg[j] = 0;
         eb[j] = 0;
      end
      for (int i = 0; i < N; i++) begin
         int s;
         s = int'(ev[2*i]) - int'(ev[2*i+1]);
         if (s != 0) cyc += N;
         for (int j = 0; j < N; j++) begin
            if (s != 0 && tbl[i][j] == 1) eg[j] = clamp(eg[j] + s);
            if (s != 0 && tbl[i][j] == 2) eb[j] = clamp(eb[j] + s);
         end
      end
   endtask

   task automatic cfg(input int s, input int t, input int c);
      cfg_we = 1'b1;
      cfg_src = IW'(s);
      cfg_tgt = IW'(t);
      cfg_code = 2'(c);
      @(posedge clk);
      #1 cfg_we = 1'b0;
      if (s < N && t < N) tbl[s][t] = (c == 1 || c == 2) ? c : 0;
   endtask

   task automatic run_frame(input logic [2*N-1:0] ev, input int inj, output int cyc);
      tstartstop = ev;
      go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      cfg_we = 1'b0;
      tstartstop = ~ev;
      cyc = 1;
      while (!done && cyc < 400) begin
         if (cyc == inj) begin
            go = 1'b1;
            cfg_we = 1'b1;
            cfg_src = IW'(1);
            cfg_tgt = IW'(1);
            cfg_code = 2'b10;
         end
         @(posedge clk);
         #1 go = 1'b0;
         cfg_we = 1'b0;
         cyc++;
      end
      if (!done) chk("frame_timeout", 64'(done), 64'd1);
   endtask

   task automatic after_done(input string name);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk({name, "_single_done"}, 64'(done), 64'd0);
      end
      chk({name, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic check_frame(input string name, input logic [2*N-1:0] ev, input int inj);
      int ecyc, cyc;
      model(ev, ecyc);
      run_frame(ev, inj, cyc);
      chk({name, "_cycles"}, 64'(cyc), 64'(ecyc));
      chk({name, "_good"}, 64'(new_good_tokens), 64'(pack(eg)));
      chk({name, "_bad"}, 64'(new_bad_tokens), 64'(pack(eb)));
      after_done(name);
   endtask

   initial begin
      int cyc;
      logic [N*B-1:0] expg, expb;
      logic [2*N-1:0] all_start;
      vt[0] = '{ev: '0, cyc: 11, g5: 0, b7: 0};
      vt[1] = '{ev: 20'h00010, cyc: 21, g5: 1, b7: 1};
      vt[2] = '{ev: 20'h00020, cyc: 21, g5: -1, b7: -1};
      vt[3] = '{ev: 20'h00030, cyc: 11, g5: 0, b7: 0};
      vt[4] = '{ev: 20'h00040, cyc: 21, g5: 0, b7: 0};
      all_start = {N{2'b01}};
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) tbl[i][j] = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_src_idx", 64'(src_idx), 64'd0);
      chk("rst_good", 64'(new_good_tokens), 64'd0);
      chk("rst_bad", 64'(new_bad_tokens), 64'd0);
      cfg(2, 5, 1);
      cfg(2, 7, 2);
      for (int i = 0; i < 5; i++) begin
         run_frame(vt[i].ev, -1, cyc);
         expg = '0;
         expb = '0;
         expg[5*B +: B] = B'(vt[i].g5);
         expb[7*B +: B] = B'(vt[i].b7);
         chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vt[i].cyc));
         chk($sformatf("vec%0d_good", i), 64'(new_good_tokens), 64'(expg));
         chk($sformatf("vec%0d_bad", i), 64'(new_bad_tokens), 64'(expb));
         after_done($sformatf("vec%0d", i));
      end
      cfg_we = 1'b1;
      cfg_src = IW'(4);
      cfg_tgt = IW'(0);
      cfg_code = 2'b10;
      tbl[4][0] = 2;
      check_frame("cfg_with_go", 20'h00100, -1);
      chk("cfg_with_go_bad0", 64'(new_bad_tokens[0 +: B]), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) tbl[i][j] = 0;
      for (int i = 0; i < N; i++) cfg(i, 3, 1);
      check_frame("sat1", all_start, -1);
      chk("sat1_good3", 64'(new_good_tokens[3*B +: B]), 64'd7);
      check_frame("sat2_busy_inject", all_start, 5);
      chk("sat2_good3", 64'(new_good_tokens[3*B +: B]), 64'd7);
      check_frame("table_unchanged", 20'h00004, -1);
      chk("table_unchanged_bad1", 64'(new_bad_tokens[1*B +: B]), 64'd0);
      tstartstop = all_start;
      go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
      repeat (14) @(posedge clk);
      #1 chk("mid_in_frame", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) tbl[i][j] = 0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_good", 64'(new_good_tokens), 64'd0);
      chk("midrst_bad", 64'(new_bad_tokens), 64'd0);
      check_frame("post_reset", all_start, -1);
      for (int r = 0; r < 15; r++) begin
         for (int w = 0; w < 12; w++) cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
         check_frame($sformatf("rand%0d", r), (2*N)'($urandom), -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
